// File: rtl/gray_rx.sv
`timescale 1ns/1ps
// gray_rx: decodes a Gray-coded counter sample stream, tracks lock on the
// +1 count sequence and reports samples that are not legal successors.
module gray_rx #(
  parameter int CBITS    = 8,
  parameter int LOSS_THR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             gray_vld,
  input  logic             clr_err,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_vld,
  output logic             wrap,
  output logic             step_err,
  output logic             err_sticky,
  output logic [7:0]       err_cnt,
  output logic             locked
);

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    LOCK = 2'd1,
    LOST = 2'd2
  } state_e;

  localparam logic [CBITS-1:0] ONE = CBITS'(1);
  localparam logic [3:0]       THR = 4'(LOSS_THR);

  state_e           state_q, state_d;
  logic [CBITS-1:0] prev_bin_q;
  logic [CBITS-1:0] dec;
  logic             have_prev_q;
  logic             pair_q, pair_d;
  logic [3:0]       bad_run_q, bad_run_d;
  logic             bin_vld_q;
  logic             wrap_q, wrap_d;
  logic             step_err_q, step_err_d;
  logic             err_sticky_q;
  logic [7:0]       err_cnt_q;
  logic             is_step, is_hold, is_bad;

  // NOTE: blocking '=' is correct here: acc must carry the running XOR from
  // the MSB down within one evaluation; sequential blocks use '<=' only.
  always_comb begin
    logic acc;
    acc = 1'b0;
    dec = '0;
    for (int i = CBITS - 1; i >= 0; i--) begin
      acc    = acc ^ gray_in[i];
      dec[i] = acc;
    end
  end

  // A repeated sample (hold) is neither legal nor bad.
  assign is_step = have_prev_q && (dec == prev_bin_q + ONE);
  assign is_hold = have_prev_q && (dec == prev_bin_q);
  assign is_bad  = have_prev_q && !is_step && !is_hold;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    bad_run_d  = bad_run_q;
    wrap_d     = 1'b0;
    step_err_d = 1'b0;
    if (gray_vld) begin
      unique case (state_q)
        ACQ, LOST: begin
          if (is_step) begin
            if (pair_q) begin
              state_d   = LOCK;
              pair_d    = 1'b0;
              bad_run_d = '0;
            end else begin
              pair_d = 1'b1;
            end
          end else if (is_bad) begin
            pair_d     = 1'b0;
            step_err_d = (state_q == LOST);
          end
        end
        LOCK: begin
          if (is_step) begin
            bad_run_d = '0;
            wrap_d    = &prev_bin_q;
          end else if (is_bad) begin
            step_err_d = 1'b1;
            bad_run_d  = bad_run_q + 4'd1;
            if (bad_run_q + 4'd1 >= THR) begin
              state_d = LOST;
              pair_d  = 1'b0;
            end
          end
        end
        default: state_d = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACQ;
      pair_q       <= 1'b0;
      bad_run_q    <= '0;
      prev_bin_q   <= '0;
      have_prev_q  <= 1'b0;
      bin_vld_q    <= 1'b0;
      wrap_q       <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      bad_run_q  <= bad_run_d;
      bin_vld_q  <= gray_vld;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
      if (gray_vld) begin
        prev_bin_q  <= dec;
        have_prev_q <= 1'b1;
      end
      // Clear beats a simultaneous error.
      if (clr_err) begin
        err_sticky_q <= 1'b0;
        err_cnt_q    <= '0;
      end else if (step_err_d) begin
        err_sticky_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // The last valid decode doubles as the presented output word.
  assign bin_out    = prev_bin_q;
  assign bin_vld    = bin_vld_q;
  assign wrap       = wrap_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_gray_rx.sv
`timescale 1ns/1ps
// tb_gray_rx: directed and randomized samples checked against a sample-level
// reference model; expected responses are queued and popped by a monitor.
module tb_gray_rx;

  localparam int CB  = 8;
  localparam int THR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CB-1:0] gray_in = '0;
  logic          gray_vld = 1'b0;
  logic          clr_err = 1'b0;
  logic [CB-1:0] bin_out;
  logic          bin_vld, wrap, step_err, err_sticky, locked;
  logic [7:0]    err_cnt;

  gray_rx #(.CBITS(CB), .LOSS_THR(THR)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .gray_vld  (gray_vld),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_vld   (bin_vld),
    .wrap      (wrap),
    .step_err  (step_err),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bin;
    logic       wrap;
    logic       serr;
    logic       sticky;
    logic [7:0] cnt;
    logic       locked;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_prev, m_good, m_bad, m_cnt;
  bit m_have, m_locked, m_seen, m_sticky;

  function automatic int g2b(input int g);
    int b = g;
    for (int s = 1; s < CB; s *= 2) b ^= b >> s;
    return b & 255;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 255;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_good = 0; m_bad = 0; m_cnt = 0;
    m_have = 0; m_locked = 0; m_seen = 0; m_sticky = 0;
  endtask

  // Applies one cycle of inputs, predicts the response, waits past the edge.
  task automatic cycle(input bit vld, input int g, input bit clr);
    exp_t e;
    bit   serr = 0;
    bit   wr   = 0;
    int   d    = 0;
    gray_vld = vld;
    gray_in  = CB'(g);
    clr_err  = clr;
    if (vld) begin
      d = g2b(g);
      if (!m_have) begin
        m_have = 1;
      end else if (d == (m_prev + 1) % 256) begin
        if (m_locked) begin
          wr    = (m_prev == 255);
          m_bad = 0;
        end else begin
          m_good++;
          if (m_good == 2) begin
            m_locked = 1; m_seen = 1; m_good = 0; m_bad = 0;
          end
        end
      end else if (d != m_prev) begin
        if (m_locked) begin
          serr = 1;
          m_bad++;
          if (m_bad >= THR) begin
            m_locked = 0; m_good = 0;
          end
        end else begin
          m_good = 0;
          serr   = m_seen;
        end
      end
      m_prev = d;
    end
    if (clr) begin
      m_cnt = 0; m_sticky = 0;
    end else if (serr) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (vld) begin
      e.bin = 8'(d); e.wrap = wr; e.serr = serr;
      e.sticky = m_sticky; e.cnt = 8'(m_cnt); e.locked = m_locked;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("bin_vld_latency", {31'd0, bin_vld}, {31'd0, vld});
  endtask

  task automatic step_legal();
    cycle(1, b2g((m_prev + 1) % 256), 0);
  endtask

  task automatic hold_sample();
    cycle(1, b2g(m_prev), 0);
  endtask

  task automatic bad_sample();
    int d;
    d = (m_prev + 2 + int'($urandom_range(0, 250))) % 256;
    cycle(1, b2g(d), 0);
  endtask

  task automatic check_now(input string tag);
    @(negedge clk);
    check({tag, "_err_cnt"},    {24'd0, err_cnt},    m_cnt);
    check({tag, "_err_sticky"}, {31'd0, err_sticky}, {31'd0, m_sticky});
    check({tag, "_locked"},     {31'd0, locked},     {31'd0, m_locked});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bin_out"},    {24'd0, bin_out},    0);
    check({tag, "_bin_vld"},    {31'd0, bin_vld},    0);
    check({tag, "_wrap"},       {31'd0, wrap},       0);
    check({tag, "_step_err"},   {31'd0, step_err},   0);
    check({tag, "_err_sticky"}, {31'd0, err_sticky}, 0);
    check({tag, "_err_cnt"},    {24'd0, err_cnt},    0);
    check({tag, "_locked"},     {31'd0, locked},     0);
  endtask

  // Monitor: pops one expectation for every presented output word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bin_vld) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bin_vld", {31'd0, bin_vld}, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("bin_out",    {24'd0, bin_out},    {24'd0, mon_e.bin});
            check("wrap",       {31'd0, wrap},       {31'd0, mon_e.wrap});
            check("step_err",   {31'd0, step_err},   {31'd0, mon_e.serr});
            check("err_sticky", {31'd0, err_sticky}, {31'd0, mon_e.sticky});
            check("err_cnt",    {24'd0, err_cnt},    {24'd0, mon_e.cnt});
            check("locked",     {31'd0, locked},     {31'd0, mon_e.locked});
          end
        end else begin
          check("wrap_idle",     {31'd0, wrap},     0);
          check("step_err_idle", {31'd0, step_err}, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    model_reset();
    #1 rst = 1'b1;
    #15 check_reset_outputs("reset");
    #7 rst = 1'b0;
    @(posedge clk);
    #1;

    // Acquisition from count 0
    cycle(1, 'h00, 0);
    cycle(1, 'h01, 0);
    cycle(1, 'h03, 0);
    check_now("acq_lock");
    cycle(1, 'h02, 0);

    // Walk up to 254 with idle gaps, then wrap through 255 -> 0
    while (m_prev != 254) begin
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0);
      step_legal();
    end
    cycle(1, 'h80, 0);
    cycle(1, 'h00, 0);
    check_now("wrap");

    // Hold handling at count 4
    while (m_prev != 3) step_legal();
    cycle(1, 'h06, 0);
    cycle(1, 'h06, 0);
    cycle(1, 'h07, 0);

    // One bad sample followed by holds, then a run of non-successors
    cycle(1, 'hFF, 0);
    cycle(1, 'hFF, 0);
    cycle(1, 'hFF, 0);
    check_now("bad_then_holds");
    cycle(1, 'h10, 0);
    cycle(1, 'h70, 0);
    cycle(1, 'h10, 0);
    check_now("loss");
    step_legal();
    step_legal();
    step_legal();
    check_now("relock");

    // Clear racing an error, both on the output pulse and on the input edge
    bad_sample();
    cycle(0, 0, 1);
    check_now("clr_vs_pulse");
    bad_sample();
    cycle(1, b2g((m_prev + 7) % 256), 1);
    check_now("clr_vs_edge");

    // Saturation
    for (int i = 0; i < 300; i++) bad_sample();
    check_now("saturate");

    // Asynchronous reset mid-stream while locked
    step_legal();
    step_legal();
    step_legal();
    check_now("pre_reset_lock");
    cycle(0, 0, 0);
    #2 rst = 1'b1;
    gray_vld = 1'b0;
    clr_err  = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, int'($urandom_range(0, 255)), 0);
    step_legal();
    check_now("post_reset_acq");
    step_legal();
    check_now("post_reset_lock");

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit clr;
      clr = ($urandom_range(0, 49) == 0);
      r   = int'($urandom_range(0, 99));
      if (r < 10)      cycle(0, 0, clr);
      else if (r < 60) cycle(1, b2g((m_prev + 1) % 256), clr);
      else if (r < 72) cycle(1, b2g(m_prev), clr);
      else if (r < 85) cycle(1, b2g((m_prev + 2 + int'($urandom_range(0, 250))) % 256), clr);
      else             cycle(1, int'($urandom_range(0, 255)), clr);
      if (i % 200 == 199) check_now("random");
    end

    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
